// File: rtl/demux4_stream_if.sv
// demux4_stream_if: source-side handshake plus the four lane outputs of demux4_stream.
// master = environment side (drives the input word and lane o_ready),
// slave  = demux side (drives in_ready, lane registers, o_valid, acc_cnt).
interface demux4_stream_if #(
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned CNT_W = 32;

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       sel;
  logic [WIDTH-1:0] o1;
  logic [WIDTH-1:0] o2;
  logic [WIDTH-1:0] o3;
  logic [WIDTH-1:0] o4;
  logic [3:0]       o_valid;
  logic [3:0]       o_ready;
  logic [CNT_W-1:0] acc_cnt;

  modport master (
    output in_data, in_valid, sel, o_ready,
    input  in_ready, o1, o2, o3, o4, o_valid, acc_cnt
  );

  modport slave (
    input  in_data, in_valid, sel, o_ready,
    output in_ready, o1, o2, o3, o4, o_valid, acc_cnt
  );
endinterface

// File: rtl/demux4_stream.sv
// demux4_stream: routes one input word stream to four independently stalling
// one-entry output lanes, counting accepted words.
// Optional build macro DEMUX4_RR_EN: ignore sel and target lanes in strict
// round-robin order via an internal 2-bit pointer that advances on accept.
module demux4_stream #(
  parameter int unsigned WIDTH = 32
) (
  input logic            clk,
  input logic            rst,
  demux4_stream_if.slave bus
);
  localparam int unsigned CNT_W = 32;

  logic [3:0][WIDTH-1:0] lane_q, lane_d;
  logic [3:0]            valid_q, valid_d;
  logic [CNT_W-1:0]      acc_q, acc_d;
  logic [1:0]            tgt;
  logic                  accept;

`ifdef DEMUX4_RR_EN
  logic [1:0] rr_q, rr_d;
  logic [1:0] unused_sel;

  assign unused_sel = bus.sel;
  assign tgt        = rr_q;

  // Round-robin pointer moves to the next lane only when a word is taken.
  always_comb begin
    rr_d = rr_q;
    if (accept) rr_d = rr_q + 2'd1;
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) rr_q <= 2'd0;
    else     rr_q <= rr_d;
  end
`else
  assign tgt = bus.sel;
`endif

  // Target lane can take a word when empty or when it drains this cycle.
  assign bus.in_ready = ~valid_q[tgt] | bus.o_ready[tgt];
  assign accept       = bus.in_valid & bus.in_ready;

  // Drain every consumed lane, then overlay the write so drain+write keeps valid high.
  always_comb begin
    lane_d  = lane_q;
    valid_d = valid_q & ~bus.o_ready;
    acc_d   = acc_q;
    if (accept) begin
      lane_d[tgt]  = bus.in_data;
      valid_d[tgt] = 1'b1;
      acc_d        = acc_q + CNT_W'(1);
    end
  end

  // Lane data, lane valid and accept counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q  <= '0;
      valid_q <= 4'd0;
      acc_q   <= '0;
    end else begin
      lane_q  <= lane_d;
      valid_q <= valid_d;
      acc_q   <= acc_d;
    end
  end

  assign bus.o1      = lane_q[0];
  assign bus.o2      = lane_q[1];
  assign bus.o3      = lane_q[2];
  assign bus.o4      = lane_q[3];
  assign bus.o_valid = valid_q;
  assign bus.acc_cnt = acc_q;
endmodule

// File: doc/demux4_stream.md
# demux4_stream

- Routes a stream of 32-bit words from one source to one of four sink lanes. It is the distribution counterpart of the `mux4` selector used in the ECG datapath: `mux4` selects one of four words, this block sends one word to one of four destinations.
- Each lane has a one-entry output register with a valid/ready handshake. Downstream lane processors can therefore stall independently without losing data.
- Sits between the sample front end and the four per-lead processing lanes.

## Interface

Parameters:
- `WIDTH`, default 32: word width of input and every output lane.

Ports:
- `clk` input 1: sole clock; everything is on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `in_data` input WIDTH: input word.
- `in_valid` input 1: input word is valid.
- `in_ready` output 1: block accepts the input word this cycle.
- `sel` input 2: target lane for `in_data`. 00→o1, 01→o2, 10→o3, 11→o4. Ignored when `DEMUX4_RR_EN` is defined.
- `o1`, `o2`, `o3`, `o4` output WIDTH each: lane data registers.
- `o_valid` output 4: bit k is valid for lane k+1.
- `o_ready` input 4: bit k means lane k+1 consumes its word this cycle.
- `acc_cnt` output 32: number of words accepted since reset.

## Operation

- Effective target lane `t`: `sel`, or the internal pointer `rr_ptr` when round-robin mode is built in.
- `in_ready = ~o_valid[t] | o_ready[t]`. This is combinational from `sel`/`rr_ptr` and `o_ready`; there is no combinational path from `in_valid`.
- Accept occurs when `in_valid & in_ready`. On accept:
  - the lane register for `t` loads `in_data`;
  - `o_valid[t]` is 1 on the next cycle;
  - `acc_cnt` increments.
- Lane drain: `o_valid[k] & o_ready[k]` with no write to lane k clears `o_valid[k]`. The data register keeps its old value.
- Simultaneous drain and write on the same lane: `o_valid` stays 1 and the register takes the new word. There is no bubble, giving full throughput per lane.
- Lanes are independent. A full lane that is not targeted never blocks writes to other lanes.
- Source rule: while `in_valid` is high and not yet accepted, `in_data` and `sel` must be held stable.
- Sink rule: a lane's `o` value and its `o_valid` change only on a handshake or on reset.
- Arithmetic: `acc_cnt` is a 32-bit unsigned counter that wraps from 0xFFFFFFFF to 0 without a flag.
- Reset values: `o1`–`o4` = 0, `o_valid` = 0, `acc_cnt` = 0, `rr_ptr` = 0. Reset mid-stream discards all buffered words. `in_ready` after reset is 1, because all lanes are empty.
- `in_valid` or `o_ready` asserted during `rst` has no effect.

## Timing

- Latency: a word accepted on edge N appears on its lane, with `o_valid` high, after edge N.
- Throughput: one word per cycle when the target lane drains every cycle or is empty.
- Lane buffer depth is 1 word.
- Worst-case stall: the source waits as long as the target lane's `o_ready` stays low.
- `o_valid`, `o1`–`o4` and `acc_cnt` are registered outputs.
- `in_ready` is combinational, with a single-gate path from `o_ready`.

## Configuration

- Macro: `DEMUX4_RR_EN`.
- When defined:
  - `sel` is ignored and `t = rr_ptr`.
  - `rr_ptr` is a 2-bit register that advances by 1 only on accept, wrapping 3→0.
  - Ordering is strict. If lane `rr_ptr` is full and not draining, `in_ready` = 0 even when other lanes are empty.
- When undefined:
  - `rr_ptr` is not instantiated and `t = sel`.
  - Port list is identical in both builds.

## Test plan

- Reset, then `sel`=10, `in_data`=0xA5A5_0001 for one cycle with all `o_ready`=0 → next cycle `o3`=0xA5A5_0001, `o_valid`=0100, `acc_cnt`=1, other lanes unchanged.
- Lane 1 full, `o_ready`=0000, `sel`=00 with `in_valid` → `in_ready`=0 and the word is held. Raise `o_ready[0]` → same cycle `in_ready`=1, next cycle `o1`=new word with `o_valid[0]` still 1.
- Back-to-back 8 words 1..8 to `sel`=01 with `o_ready[1]`=1 every cycle → 8 accepts in 8 cycles, `o2` shows 1..8 consecutively, `acc_cnt`=8.
- Lanes 1 and 2 full, `sel`=11 → `in_ready`=1 and lane 4 loads, proving lane independence.
- `rst` asserted while `o_valid`=1111 → next cycle `o_valid`=0000, `o1`–`o4`=0, `acc_cnt`=0.
- With `DEMUX4_RR_EN`: words 10,11,12,13,14 with `sel` held at 00 and all `o_ready`=1 → lanes 1,2,3,4,1 receive them in order. Then hold lane 2 full with `o_ready[1]`=0 at `rr_ptr`=1 → `in_ready`=0 despite other lanes being empty.
